xgmii_rx_frame_checker: RTL and testbench
=========================================

// Module: xgmii_rx_frame_checker
// PURPOSE
//  Sink stage for the 64-bit/8-lane XGMII-style stream from the traffic generator.
//  Tracks frames (START..TERMINATE) word by word and measures each frame's byte length.
//  Flags protocol, oversize and (optional) payload-pattern errors.
//  Keeps saturating frame/error counters for the self-checking bench.
// PARAMETERS
//  DATA_WIDTH       64     rx data width; 8 lanes x 8 bits; lane0 = [7:0] = first on wire
//  CTRL_WIDTH       8      one ctrl bit per lane; 1 = control character
//  IDLE_CODE        8'h07  idle control character
//  START_CODE       8'hFB  start control character, legal only in lane0
//  TERM_CODE        8'hFD  terminate control character
//  DATA_PATTERN     8'hAA  expected payload byte (used only with PATTERN_CHECK_EN)
//  MAX_FRAME_BYTES  256    frame longer than this aborts with oversize error
// PORTS
//  clk           in   1   clock, all logic on rising edge
//  i_rst         in   1   reset, asynchronous, active-high
//  i_rx_data     in   64  rx data word, sampled every cycle
//  i_rx_ctrl     in   8   rx ctrl lanes
//  o_frame_done  out  1   1-cycle pulse: frame ended (good or bad)
//  o_frame_len   out  16  payload bytes of finished frame; valid with o_frame_done
//  o_frame_err   out  1   finished frame was bad; valid with o_frame_done
//  o_err_code    out  2   0 none, 1 protocol, 2 oversize, 3 pattern
//  o_frame_cnt   out  32  good frames, saturating at 32'hFFFF_FFFF
//  o_err_cnt     out  32  errors (bad frames + stray ctrl words in IDLE), saturating
// BEHAVIOUR
//  - Reset: state IDLE, byte accumulator 0, all outputs 0. Reset mid-frame discards frame.
//  - All outputs registered; o_frame_done asserts cycle N+1 for TERMINATE/error word at N.
//  - Word classes: IDLE_W = ctrl 8'hFF and all lanes 07; START_W = ctrl 8'h01, lane0 FB;
//    DATA_W = ctrl 8'h00; TERM_W = lowest ctrl lane k holds FD, lanes <k ctrl=0,
//    lanes >k ctrl=1 and 07 (k in 0..7). Anything else is MALFORMED.
//  - IDLE: IDLE_W stay; DATA_W silently discarded (covers post-reset zeros);
//    START_W -> PAYLOAD, accumulator = 7; TERM_W/MALFORMED -> o_err_cnt+1, stay, no pulse.
//  - PAYLOAD: DATA_W -> accumulator += 8; TERM_W -> accumulator += k, pulse done,
//    err=0, code 0, o_frame_cnt+1, -> IDLE. Zero-length allowed (FD lane0 after START: len 7).
//  - PAYLOAD: IDLE_W, START_W or MALFORMED -> pulse done, err=1, code 1, o_err_cnt+1,
//    -> IDLE; the offending word is not re-evaluated (a START_W here is not a new frame).
//  - Oversize: if accumulator after update > MAX_FRAME_BYTES -> pulse done, err=1, code 2,
//    o_err_cnt+1, o_frame_len = MAX_FRAME_BYTES, -> IDLE; the remaining frame words
//    are discarded until the next START_W (DATA_W ignored, TERM_W counts as stray error).
//  - Priority when several errors hit in one word: protocol > oversize > pattern.
//  - Accumulator 16 bits, saturating; counters saturate, never wrap.
// CONFIGURATION
//  - PATTERN_CHECK_EN defined: every payload byte (START_W lanes1-7, DATA_W, TERM_W lanes <k)
//    compared to DATA_PATTERN; any mismatch latches a sticky flag; at TERM_W frame reports
//    err=1, code 3, counted in o_err_cnt not o_frame_cnt. Flag cleared on START_W.
//  - Not defined: no comparison logic; code 3 never produced; payload contents ignored.
// TESTING
//  - Reset, then 4 IDLE_W -> all outputs 0, both counters 0.
//  - START_W, 2 DATA_W, TERM_W k=3 -> pulse 1 cycle later, len 26, err 0, o_frame_cnt 1.
//  - START_W directly followed by TERM_W k=0 -> len 7, err 0; k=7 -> len 14.
//  - START_W, DATA_W, IDLE_W -> pulse, err 1, code 1, o_err_cnt 1; next START_W frame good.
//  - MAX_FRAME_BYTES=32: START_W + 4 DATA_W -> pulse on 4th DATA_W (39>32), code 2, len 32.
//  - PATTERN_CHECK_EN: one DATA_W byte 8'h55 then TERM_W k=2 -> err 1, code 3;
//    without macro same stimulus -> err 0, o_frame_cnt+1.

Source files
------------

// File: rtl/xgmii_rx_frame_checker.sv
// XGMII-style 8-lane rx frame checker: classifies words, measures frame length,
// flags protocol/oversize errors and keeps saturating counters. Optional macro PATTERN_CHECK_EN
// enables payload-byte comparison against DATA_PATTERN.
module xgmii_rx_frame_checker #(
  parameter int          DATA_WIDTH      = 64,
  parameter int          CTRL_WIDTH      = 8,
  parameter logic [7:0]  IDLE_CODE       = 8'h07,
  parameter logic [7:0]  START_CODE      = 8'hFB,
  parameter logic [7:0]  TERM_CODE       = 8'hFD,
  parameter logic [7:0]  DATA_PATTERN    = 8'hAA,
  parameter int          MAX_FRAME_BYTES = 256
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_len,
  output logic                  o_frame_err,
  output logic [1:0]            o_err_code,
  output logic [31:0]           o_frame_cnt,
  output logic [31:0]           o_err_cnt
);

  localparam int LW = $clog2(CTRL_WIDTH);
  localparam logic [CTRL_WIDTH-1:0] CTRL_ALL = '1;
  localparam logic [16:0] MAX_L = 17'(MAX_FRAME_BYTES);
  localparam logic [1:0] CODE_NONE = 2'd0, CODE_PROTO = 2'd1, CODE_OVER = 2'd2, CODE_PAT = 2'd3;

  typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

  state_t        state_q;
  logic [15:0]   acc_q;
  logic          done_q, err_q;
  logic [15:0]   len_q;
  logic [1:0]    code_q;
  logic [31:0]   frame_cnt_q, err_cnt_q;

  logic          is_idle, is_start, is_data, is_term;
  logic [LW-1:0] term_k;
  logic [16:0]   acc_sum;
  logic [15:0]   acc_upd;
  logic          oversize;
  logic          pat_seen;

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Word classification. TERM position k is the lowest lane with its ctrl bit set.
  always_comb begin
    is_idle  = (i_rx_ctrl == CTRL_ALL);
    is_start = (i_rx_ctrl == CTRL_WIDTH'(1)) && (i_rx_data[7:0] == START_CODE);
    is_data  = (i_rx_ctrl == '0);
    term_k   = '0;
    for (int i = CTRL_WIDTH-1; i >= 0; i--)
      if (i_rx_ctrl[i]) term_k = LW'(i);
    is_term  = (i_rx_ctrl != '0) && (i_rx_ctrl == (CTRL_ALL << term_k));
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (i_rx_data[i*8 +: 8] != IDLE_CODE) is_idle = 1'b0;
      if (i == int'(term_k)) begin
        if (i_rx_data[i*8 +: 8] != TERM_CODE) is_term = 1'b0;
      end else if (i > int'(term_k) && i_rx_data[i*8 +: 8] != IDLE_CODE) begin
        is_term = 1'b0;
      end
    end
  end

  always_comb begin
    acc_sum  = {1'b0, acc_q} + (is_data ? 17'd8 : 17'(term_k));
    acc_upd  = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    oversize = ({1'b0, acc_upd} > MAX_L);
  end

`ifdef PATTERN_CHECK_EN
  logic pat_q, pat_now;

  always_comb begin
    pat_now = 1'b0;
    for (int i = 0; i < CTRL_WIDTH; i++)
      if ((is_data || (is_start && i > 0) || (is_term && i < int'(term_k))) &&
          i_rx_data[i*8 +: 8] != DATA_PATTERN)
        pat_now = 1'b1;
  end

  // Sticky mismatch flag; a START_W seeds it from its own payload lanes.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) pat_q <= 1'b0;
    else if (state_q == S_IDLE && is_start) pat_q <= pat_now;
    else if (state_q == S_PAYLOAD && is_data) pat_q <= pat_q | pat_now;
  end

  assign pat_seen = pat_q | pat_now;
`else
  assign pat_seen = 1'b0;
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      done_q      <= 1'b0;
      len_q       <= '0;
      err_q       <= 1'b0;
      code_q      <= CODE_NONE;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      len_q  <= '0;
      err_q  <= 1'b0;
      code_q <= CODE_NONE;
      case (state_q)
        S_IDLE: begin
          if (is_start) begin
            state_q <= S_PAYLOAD;
            acc_q   <= 16'd7;
          end else if (!is_idle && !is_data) begin
            err_cnt_q <= inc_sat(err_cnt_q);
          end
        end
        S_PAYLOAD: begin
          // Every branch except a normal DATA_W ends the frame.
          done_q  <= 1'b1;
          state_q <= S_IDLE;
          if (!(is_data || is_term)) begin
            err_q     <= 1'b1;
            code_q    <= CODE_PROTO;
            len_q     <= acc_q;
            err_cnt_q <= inc_sat(err_cnt_q);
          end else if (oversize) begin
            err_q     <= 1'b1;
            code_q    <= CODE_OVER;
            len_q     <= 16'(MAX_FRAME_BYTES);
            err_cnt_q <= inc_sat(err_cnt_q);
          end else if (is_data) begin
            done_q  <= 1'b0;
            state_q <= S_PAYLOAD;
            acc_q   <= acc_upd;
          end else if (pat_seen) begin
            err_q     <= 1'b1;
            code_q    <= CODE_PAT;
            len_q     <= acc_upd;
            err_cnt_q <= inc_sat(err_cnt_q);
          end else begin
            len_q       <= acc_upd;
            frame_cnt_q <= inc_sat(frame_cnt_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_frame_done = done_q;
  assign o_frame_len  = len_q;
  assign o_frame_err  = err_q;
  assign o_err_code   = code_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_frame_checker.sv
// Table-driven bench for xgmii_rx_frame_checker (MAX_FRAME_BYTES=32) plus a mid-frame reset sequence.
module tb_xgmii_rx_frame_checker;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_rx_data;
  logic [7:0]  i_rx_ctrl;
  logic        o_frame_done, o_frame_err;
  logic [15:0] o_frame_len;
  logic [1:0]  o_err_code;
  logic [31:0] o_frame_cnt, o_err_cnt;

  always #5 clk = ~clk;

  xgmii_rx_frame_checker #(.MAX_FRAME_BYTES(32)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_ctrl(i_rx_ctrl),
    .o_frame_done(o_frame_done), .o_frame_len(o_frame_len), .o_frame_err(o_frame_err),
    .o_err_code(o_err_code), .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
  );

`ifdef PATTERN_CHECK_EN
  localparam int PAT = 1;
`else
  localparam int PAT = 0;
`endif

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        done;
    logic [15:0] len;
    logic        err;
    logic [1:0]  code;
    logic [31:0] fcnt;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] IDLE_D  = 64'h0707_0707_0707_0707;
  localparam logic [63:0] START_D = 64'hAAAA_AAAA_AAAA_AAFB;
  localparam logic [63:0] DATA_D  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BAD_D   = 64'hAAAA_AAAA_AAAA_55AA;

  function automatic logic [63:0] term_d(input int k);
    logic [63:0] d;
    d = IDLE_D;
    for (int i = 0; i < k; i++) d[i*8 +: 8] = 8'hAA;
    d[k*8 +: 8] = 8'hFD;
    return d;
  endfunction

  function automatic logic [7:0] term_c(input int k);
    logic [7:0] c;
    c = 8'hFF;
    return c << k;
  endfunction

  task automatic row(input logic [63:0] d, input logic [7:0] c, input int f, input int e);
    vec_t v;
    v = '{d, c, 1'b0, 16'd0, 1'b0, 2'd0, 32'(f), 32'(e)};
    vq.push_back(v);
  endtask

  task automatic rowd(input logic [63:0] d, input logic [7:0] c, input int len,
                      input int err, input int code, input int f, input int e);
    vec_t v;
    v = '{d, c, 1'b1, 16'(len), err[0], code[1:0], 32'(f), 32'(e)};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".done"}, 64'(o_frame_done), 64'(v.done));
    chk({tag, ".len"},  64'(o_frame_len),  64'(v.len));
    chk({tag, ".err"},  64'(o_frame_err),  64'(v.err));
    chk({tag, ".code"}, 64'(o_err_code),   64'(v.code));
    chk({tag, ".fcnt"}, 64'(o_frame_cnt),  64'(v.fcnt));
    chk({tag, ".ecnt"}, 64'(o_err_cnt),    64'(v.ecnt));
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c);
    i_rx_data = d;
    i_rx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t z;
    vec_t v;
    z = '{64'd0, 8'd0, 1'b0, 16'd0, 1'b0, 2'd0, 32'd0, 32'd0};

    // Idle, then basic good frames of varying termination lanes.
    for (int i = 0; i < 4; i++) row(IDLE_D, 8'hFF, 0, 0);
    row(START_D, 8'h01, 0, 0); row(DATA_D, 8'h00, 0, 0); row(DATA_D, 8'h00, 0, 0);
    rowd(term_d(3), term_c(3), 26, 0, 0, 1, 0);
    row(IDLE_D, 8'hFF, 1, 0);
    row(START_D, 8'h01, 1, 0); rowd(term_d(0), term_c(0), 7, 0, 0, 2, 0);
    row(START_D, 8'h01, 2, 0); rowd(term_d(7), term_c(7), 14, 0, 0, 3, 0);
    // Protocol error (IDLE mid-frame), then a good frame.
    row(START_D, 8'h01, 3, 0); row(DATA_D, 8'h00, 3, 0);
    rowd(IDLE_D, 8'hFF, 15, 1, 1, 3, 1);
    row(START_D, 8'h01, 3, 1); row(DATA_D, 8'h00, 3, 1);
    rowd(term_d(1), term_c(1), 16, 0, 0, 4, 1);
    // Stray words in IDLE.
    row(IDLE_D, 8'hFF, 4, 1);
    row(term_d(0), term_c(0), 4, 2);
    row(64'd0, 8'h0F, 4, 3);
    row(DATA_D, 8'h00, 4, 3);
    // Exactly MAX bytes is good.
    row(START_D, 8'h01, 4, 3);
    for (int i = 0; i < 3; i++) row(DATA_D, 8'h00, 4, 3);
    rowd(term_d(1), term_c(1), 32, 0, 0, 5, 3);
    // Oversize on 4th DATA_W; tail discarded, TERM_W counts as stray.
    row(START_D, 8'h01, 5, 3);
    for (int i = 0; i < 3; i++) row(DATA_D, 8'h00, 5, 3);
    rowd(DATA_D, 8'h00, 32, 1, 2, 5, 4);
    row(DATA_D, 8'h00, 5, 4);
    row(term_d(3), term_c(3), 5, 5);
    row(IDLE_D, 8'hFF, 5, 5);
    // Oversize on TERM_W (31 + 2 = 33).
    row(START_D, 8'h01, 5, 5);
    for (int i = 0; i < 3; i++) row(DATA_D, 8'h00, 5, 5);
    rowd(term_d(2), term_c(2), 32, 1, 2, 5, 6);
    // START_W inside a frame is a protocol error, not a new frame.
    row(START_D, 8'h01, 5, 6);
    rowd(START_D, 8'h01, 7, 1, 1, 5, 7);
    // Pattern mismatch byte.
    row(START_D, 8'h01, 5, 7); row(BAD_D, 8'h00, 5, 7);
    rowd(term_d(2), term_c(2), 17, PAT, PAT * 3, 6 - PAT, 7 + PAT);
    // Malformed word mid-frame.
    row(START_D, 8'h01, 6 - PAT, 7 + PAT);
    rowd(IDLE_D, 8'h80, 7, 1, 1, 6 - PAT, 8 + PAT);

    i_rst     = 1'b1;
    i_rx_data = IDLE_D;
    i_rx_ctrl = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", z);
    i_rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      step(v.d, v.c);
      chk_all($sformatf("v%0d", i), v);
    end

    // Reset mid-frame discards the frame; the orphan TERM_W is then a stray error.
    step(START_D, 8'h01);
    step(DATA_D, 8'h00);
    i_rst = 1'b1;
    #1;
    chk_all("midrst", z);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    step(term_d(3), term_c(3));
    chk("post_rst.done", 64'(o_frame_done), 64'd0);
    chk("post_rst.ecnt", 64'(o_err_cnt), 64'd1);
    chk("post_rst.fcnt", 64'(o_frame_cnt), 64'd0);
    step(START_D, 8'h01);
    step(term_d(0), term_c(0));
    chk("rst_frame.done", 64'(o_frame_done), 64'd1);
    chk("rst_frame.len", 64'(o_frame_len), 64'd7);
    chk("rst_frame.fcnt", 64'(o_frame_cnt), 64'd1);
    step(IDLE_D, 8'hFF);
    chk("pulse_width.done", 64'(o_frame_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
